// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver state encoding, scan code constants and frame length
package ps2_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;
  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXTEND  = 8'hE0;
  localparam int         FRAME_BITS = 11;
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronise ps2_clk/ps2_data, deglitch ps2_clk, strobe its falling edges
// Ports: clk, rst (async active-low), i_ps2_clk/i_ps2_data raw device lines,
//        o_fall one-clk strobe per filtered 1->0 edge, o_data synchronised data line.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fall,
  output logic o_data
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_filt;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_flip;
  // r_cnt tracks how long the synchronised clock has disagreed with the filtered level
  assign w_diff = r_clk_s[1] != r_filt;
  assign w_flip = w_diff && (r_cnt == CW'(FILTER_LEN - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_filt  <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], i_ps2_clk};
      r_dat_s <= {r_dat_s[0], i_ps2_data};
      r_cnt   <= (w_diff && !w_flip) ? r_cnt + CW'(1) : '0;
      r_filt  <= w_flip ? r_clk_s[1] : r_filt;
      r_fall  <= w_flip && !r_clk_s[1];
    end
  end
  assign o_fall = r_fall;
  assign o_data = r_dat_s[1];
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver (start, 8 data LSB-first, parity, stop)
// Ports: clk, rst (async active-low), ps2_clk/ps2_data raw device lines,
//        data_out last accepted byte, data_ready/frame_err/parity_err one-clk pulses.
// Define PS2_RX_PARITY_CHECK_EN to enforce odd parity; otherwise parity_err is tied 0.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LAST_BIT = 3'(FRAME_BITS - 4);
  ps2_state_t    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [TW-1:0] r_tmo;
  logic          w_fall;
  logic          w_data;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic          r_par;
`endif
  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk        (clk),
    .rst        (rst),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_fall     (w_fall),
    .o_data     (w_data)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tmo      <= '0;
      data_out   <= 8'h00;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      r_par      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
      if (r_state == ST_IDLE) begin
        r_tmo <= '0;
        if (w_fall) begin
          r_bit_cnt <= '0;
          if (w_data) frame_err <= 1'b1;
          else r_state <= ST_DATA;
        end
      end else if (!w_fall && r_tmo == TMO_LAST) begin
        // device stalled mid-frame: drop the partial byte
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_tmo     <= '0;
        frame_err <= 1'b1;
      end else if (!w_fall) begin
        r_tmo <= r_tmo + TW'(1);
      end else begin
        r_tmo <= '0;
        case (r_state)
          ST_DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == LAST_BIT) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
            r_par   <= w_data;
`endif
            r_state <= ST_STOP;
          end
          default: begin
            r_state <= ST_IDLE;
            if (!w_data) frame_err <= 1'b1;
`ifdef PS2_RX_PARITY_CHECK_EN
            else if (!odd_parity_ok(r_shift, r_par)) parity_err <= 1'b1;
`endif
            else begin
              data_out   <= r_shift;
              data_ready <= 1'b1;
            end
          end
        endcase
      end
    end
  end
`ifndef PS2_RX_PARITY_CHECK_EN
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed plus randomized frames against a frame-level outcome model
module tb_ps2_rx;
  import ps2_pkg::*;
  localparam int HALF  = 20;
  localparam int TMO   = 50000;
  localparam int K_RDY = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data_out;
  logic       data_ready;
  logic       frame_err;
  logic       parity_err;
  int         total = 0;
  int         bad = 0;
  int         ev_kind[$];
  logic [7:0] ev_data[$];
  logic [7:0] model_dout = 8'h00;
  ps2_rx dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_out   (data_out),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst && (data_ready || frame_err || parity_err)) begin
      chk("one_pulse", 32'(int'(data_ready) + int'(frame_err) + int'(parity_err)), 32'd1);
      ev_kind.push_back(data_ready ? K_RDY : frame_err ? K_FERR : K_PERR);
      ev_data.push_back(data_ready ? data_out : 8'h00);
    end
  end
  function automatic int model_kind(input logic flip, input logic stop);
    return !stop ? K_FERR : (PAR_EN && flip) ? K_PERR : K_RDY;
  endfunction
  task automatic send_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
    logic [FRAME_BITS-1:0] f;
    f = {stop, ~^b ^ flip, b, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask
  task automatic expect_ev(input string tag, input int k, input logic [7:0] b);
    if (k == K_RDY) model_dout = b;
    chk({tag, "_n"}, 32'(ev_kind.size()), 32'd1);
    if (ev_kind.size() > 0) begin
      chk({tag, "_kind"}, 32'(ev_kind[0]), 32'(k));
      if (k == K_RDY) chk({tag, "_data"}, 32'(ev_data[0]), 32'(b));
    end
    chk({tag, "_dout"}, 32'(data_out), 32'(model_dout));
    ev_kind.delete();
    ev_data.delete();
  endtask
  task automatic frame_check(input string tag, input logic [7:0] b, input logic flip, input logic stop);
    send_frame(b, flip, stop);
    expect_ev(tag, model_kind(flip, stop), b);
  endtask
  task automatic glitch();
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (6) @(negedge clk);
  endtask
  initial begin
    logic [7:0] rb;
    logic       rf;
    logic       rs;
    repeat (4) @(negedge clk);
    chk("rst_dout", 32'(data_out), 32'h00);
    chk("rst_rdy", 32'(data_ready), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    rst = 1'b1;
    repeat (10) @(negedge clk);
    frame_check("f1d", 8'h1D, 1'b0, 1'b1);
    send_frame(SC_BREAK, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b1);
    model_dout = 8'h1D;
    chk("b2b_n", 32'(ev_kind.size()), 32'd2);
    if (ev_kind.size() == 2) begin
      chk("b2b_k0", 32'(ev_kind[0]), 32'(K_RDY));
      chk("b2b_d0", 32'(ev_data[0]), 32'hF0);
      chk("b2b_k1", 32'(ev_kind[1]), 32'(K_RDY));
      chk("b2b_d1", 32'(ev_data[1]), 32'h1D);
    end
    chk("b2b_dout", 32'(data_out), 32'(model_dout));
    ev_kind.delete();
    ev_data.delete();
    frame_check("par", 8'h1C, 1'b1, 1'b1);
    frame_check("stop0", 8'h5A, 1'b0, 1'b0);
    send_bit(1'b1);
    repeat (2 * HALF) @(negedge clk);
    expect_ev("start1", K_FERR, 8'h00);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    ps2_data = 1'b1;
    repeat (TMO + 100) @(negedge clk);
    expect_ev("tmo", K_FERR, 8'h00);
    chk("tmo_state", 32'(dut.r_state), 32'(ST_IDLE));
    frame_check("f29", 8'h29, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) glitch();
    send_bit(1'b0);
    glitch();
    for (int i = 0; i < 4; i++) begin
      send_bit(1'($urandom));
      glitch();
    end
    repeat (30) @(negedge clk);
    chk("gl_cnt", 32'(dut.r_bit_cnt), 32'd4);
    chk("gl_state", 32'(dut.r_state), 32'(ST_DATA));
    chk("gl_nev", 32'(ev_kind.size()), 32'd0);
    rst = 1'b0;
    model_dout = 8'h00;
    repeat (5) @(negedge clk);
    chk("mr_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("mr_dout", 32'(data_out), 32'h00);
    rst = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    chk("mr_nev", 32'(ev_kind.size()), 32'd0);
    frame_check("f23", 8'h23, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom);
      rf = ($urandom_range(3) == 0);
      rs = ($urandom_range(7) != 0);
      frame_check("rnd", rb, rf, rs);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
